// File: rtl/lock_code_sender.sv
// Plays a stored combination onto a switch-controlled lock (clear pulse, then
// digit/strobe/release per digit) and reports whether the lock opened.
module lock_code_sender #(
  parameter int DIGITS      = 7,
  parameter int DW          = 4,
  parameter int SETUP_CYC   = 10,
  parameter int STROBE_CYC  = 5,
  parameter int GAP_CYC     = 10,
  parameter int TIMEOUT_CYC = 20
) (
  input  logic                 CLOCK_50,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 abort,
  input  logic [DIGITS*DW-1:0] code_in,
  input  logic                 unlocked_i,
  output logic [DW-1:0]        sw_o,
  output logic                 key_o,
  output logic                 clr_o,
  output logic                 busy,
  output logic [2:0]           digit_idx,
  output logic                 done,
  output logic                 pass
);

  localparam int M1   = (SETUP_CYC > STROBE_CYC) ? SETUP_CYC : STROBE_CYC;
  localparam int M2   = (GAP_CYC > TIMEOUT_CYC) ? GAP_CYC : TIMEOUT_CYC;
  localparam int MAXC = (M1 > M2) ? M1 : M2;
  localparam int CW   = $clog2(MAXC + 1);

  typedef enum logic [3:0] {
    S_IDLE, S_LATCH, S_CLEAR, S_CGAP, S_SETUP, S_STROBE, S_GAP, S_CHECK, S_DONE
  } state_t;

  state_t               state, state_n;
  logic [CW-1:0]        cnt, cnt_n;
  logic [2:0]           idx_n;
  logic                 pass_n;
  logic                 accept;
  logic [DIGITS*DW-1:0] code_lat;
  logic [DIGITS*DW-1:0] shifted;

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state     <= S_IDLE;
      cnt       <= '0;
      digit_idx <= '0;
      pass      <= 1'b0;
      code_lat  <= '0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      digit_idx <= idx_n;
      pass      <= pass_n;
      if (accept) code_lat <= code_in;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt + 1'b1;
    idx_n   = digit_idx;
    pass_n  = pass;
    accept  = 1'b0;
    case (state)
      S_IDLE: begin
        cnt_n = '0;
        if (start && !abort) begin
          accept  = 1'b1;
          pass_n  = 1'b0;
          idx_n   = '0;
          state_n = S_LATCH;
        end
      end
      // Single accept cycle so the clear pulse occupies cycles 1..STROBE_CYC.
      S_LATCH: begin
        cnt_n   = '0;
        state_n = S_CLEAR;
      end
      S_CLEAR:
        if (cnt == CW'(STROBE_CYC - 1)) begin
          cnt_n   = '0;
          state_n = S_CGAP;
        end
      S_CGAP:
        if (cnt == CW'(GAP_CYC - 1)) begin
          cnt_n   = '0;
          idx_n   = '0;
          state_n = S_SETUP;
        end
      S_SETUP:
        if (cnt == CW'(SETUP_CYC - 1)) begin
          cnt_n   = '0;
          state_n = S_STROBE;
        end
      S_STROBE:
        if (cnt == CW'(STROBE_CYC - 1)) begin
          cnt_n   = '0;
          state_n = S_GAP;
        end
      S_GAP:
        if (cnt == CW'(GAP_CYC - 1)) begin
          cnt_n = '0;
          if (digit_idx < 3'(DIGITS - 1)) begin
            idx_n   = digit_idx + 3'd1;
            state_n = S_SETUP;
          end else begin
            state_n = S_CHECK;
          end
        end
      S_CHECK:
        if (unlocked_i) begin
          cnt_n   = '0;
          pass_n  = 1'b1;
          state_n = S_DONE;
        end else if (cnt == CW'(TIMEOUT_CYC - 1)) begin
          cnt_n   = '0;
          pass_n  = 1'b0;
          state_n = S_DONE;
        end
      S_DONE: begin
        cnt_n   = '0;
        idx_n   = '0;
        state_n = S_IDLE;
      end
      default: begin
        cnt_n   = '0;
        state_n = S_IDLE;
      end
    endcase
    if (abort && state != S_IDLE) begin
      state_n = S_IDLE;
      cnt_n   = '0;
      idx_n   = '0;
      pass_n  = 1'b0;
      accept  = 1'b0;
    end
  end

  // First digit sent is the most-significant nibble of the latched code.
  always_comb begin
    shifted = code_lat >> (DW * (DIGITS - 1 - int'(digit_idx)));
    sw_o    = '0;
    if (state == S_SETUP || state == S_STROBE || state == S_GAP)
      sw_o = shifted[DW-1:0];
  end

  assign clr_o = (state == S_CLEAR);
  assign key_o = (state == S_STROBE);
  assign busy  = (state != S_IDLE);
  assign done  = (state == S_DONE);

endmodule

// File: doc/lock_code_sender.md
Name: lock_code_sender

Overview:
- Transmitter side of the switch-controlled lock's entry interface.
- Plays a stored multi-digit combination onto a lock: one clear pulse, then each digit on a 4-bit switch bus, each followed by an enter strobe. The timing matches manual entry (digit settles, strobe, release).
- After the last digit, watches the lock's unlocked indicator and reports pass/fail.
- Used for self-test on the DE0-Nano-SoC baseline top and as a bench driver.

Parameters:
- DIGITS, 7: number of combination digits.
- DW, 4: digit width in bits.
- SETUP_CYC, 10: cycles a digit is stable before its strobe.
- STROBE_CYC, 5: strobe and clear pulse length in cycles.
- GAP_CYC, 10: cycles after a strobe or clear is released.
- TIMEOUT_CYC, 20: cycles to wait for the unlock indication.

Ports:
- CLOCK_50  in  1  system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  begin a transmission; sampled in IDLE only.
- abort  in  1  cancel a transmission in progress.
- code_in  in  DIGITS*DW  combination; latched on accepted start. The first digit sent is the MS nibble.
- unlocked_i  in  1  lock's unlocked indication.
- sw_o  out  DW  digit presented to the lock's switch input.
- key_o  out  1  enter strobe to the lock.
- clr_o  out  1  lock clear/return-to-state-0 pulse.
- busy  out  1  high in every state except IDLE.
- digit_idx  out  3  index of the digit being sent, 0..DIGITS-1.
- done  out  1  one-cycle pulse at end of transmission.
- pass  out  1  result; valid from done until the next accepted start.

Behaviour:
- Reset values: sw_o=0, key_o=0, clr_o=0, busy=0, digit_idx=0, done=0, pass=0; state IDLE; internal counters 0.
- Internal counter is wide enough for the maximum of all *_CYC parameters. Each phase lasts exactly its parameter count.
- Cycle numbering: start is sampled high in IDLE at edge E0. Cycle n means the cycle following edge E0+n.
- IDLE:
  - start=1 and abort=0: latch code_in, clear pass, go to CLEAR.
  - start=1 and abort=1 together: abort wins, stay in IDLE.
- CLEAR: clr_o=1 for STROBE_CYC cycles (cycles 1..5 at defaults), then CGAP.
- CGAP: clr_o=0 for GAP_CYC cycles, then SETUP with digit_idx=0.
- SETUP: sw_o=code digit[digit_idx], key_o=0, for SETUP_CYC cycles, then STROBE.
- STROBE: key_o=1 and sw_o held, for STROBE_CYC cycles, then GAP.
- GAP: key_o=0 and sw_o held, for GAP_CYC cycles.
  - If digit_idx < DIGITS-1: increment digit_idx, go to SETUP.
  - Otherwise: go to CHECK.
- Digit mapping: digit k = code_lat[(DIGITS-k)*DW-1 -: DW]. sw_o changes only on SETUP entry, never while key_o=1.
- CHECK: sw_o=0, key_o=0.
  - unlocked_i=1 in any of the first TIMEOUT_CYC cycles, including the first: go to DONE with pass=1.
  - Counter expiry with unlocked_i never high: go to DONE with pass=0.
- DONE: done=1 for one cycle, busy=1, then IDLE. pass holds its value.
- Latency at defaults: CHECK is entered at cycle 5+10+7*25+1 = 191.
- abort=1 in any non-IDLE state: next cycle is IDLE with all outputs at reset values except pass=0. No done pulse.
- reset mid-operation: identical to abort.
- start while busy: ignored. code_in changes while busy: no effect (latched copy is used).
- key_o and clr_o are never high in the same cycle.

Test Plan:
- Default params, code_in=28'h0913011, lock model unlocks on correct sequence → clr_o high in cycles 1-5; sw_o sequence 0,9,1,3,0,1,1, each stable 10 cycles before a 5-cycle key_o pulse; done pulses with pass=1 within 20 cycles of CHECK entry.
- code_in=28'h6913011 against the same lock → 7 strobes sent; unlocked_i stays 0; done pulses exactly TIMEOUT_CYC cycles after CHECK entry with pass=0.
- Assert abort during the 3rd digit's STROBE (digit_idx=2) → next cycle busy=0, key_o=0, sw_o=0, no done pulse. A subsequent start runs a full sequence from clr_o.
- Assert reset during CGAP → same response as abort. start and abort high together in IDLE → stays IDLE, busy=0.
- Re-pulse start and change code_in mid-transmission → no restart; transmitted digits match the originally latched code.
- unlocked_i already 1 on CHECK entry → done the following cycle with pass=1. SVA check: key_o&clr_o never 1; sw_o stable while key_o=1.
